// File: rtl/signed_mac_pkg.sv
// Shared types and helpers for the signed streaming multiply-accumulate stage.
package signed_mac_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef enum logic {ACC_IDLE, ACC_RUN} acc_state_t;
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  // Signed-add overflow from the sign bits of both addends (a, b) and the sum (s):
  // same-signed addends producing a differently-signed sum.
  function automatic logic sadd_ovf(input logic a, input logic b, input logic s);
    return (a == b) && (s != a);
  endfunction

endpackage

// File: rtl/signed_arrayMul.sv
// Combinational 4x4 two's-complement array multiplier (Baugh-Wooley form).
module signed_arrayMul
  import signed_mac_pkg::*;
(
  input  logic signed [OP_W-1:0]   a,
  input  logic signed [OP_W-1:0]   b,
  output logic signed [PROD_W-1:0] p
);

  // Correction constant 2^(2n-1) + 2^n that replaces the negative-weight
  // partial products by their complements.
  localparam logic [PROD_W-1:0] BW_K = 8'h90;

  logic [PROD_W-1:0] row [OP_W];
  logic [PROD_W-1:0] p_sum;

  // Partial-product rows: terms mixing exactly one sign bit are inverted.
  always_comb begin
    for (int i = 0; i < OP_W; i++) begin
      row[i] = '0;
      for (int j = 0; j < OP_W; j++) begin
        if ((i == OP_W-1) != (j == OP_W-1))
          row[i][i+j] = ~(a[i] & b[j]);
        else
          row[i][i+j] = a[i] & b[j];
      end
    end
  end

  // Row reduction plus correction, modulo 2^PROD_W.
  always_comb begin
    p_sum = BW_K;
    for (int i = 0; i < OP_W; i++)
      p_sum = p_sum + row[i];
    p = signed'(p_sum);
  end

endmodule

// File: rtl/signed_mac4_stream.sv
// Streaming signed dot-product: operand register, multiply, accumulate,
// one held result (sum, term count, sticky overflow) per vector.
module signed_mac4_stream
  import signed_mac_pkg::*;
#(
  parameter int ACC_W   = 12,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = $clog2(MAX_LEN+1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [OP_W-1:0]  in_a,
  input  logic signed [OP_W-1:0]  in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0]        out_len,
  output logic                    out_ovf
);

  logic                     vld_p1, last_p1;
  logic signed [OP_W-1:0]   a_p1, b_p1;
  logic signed [PROD_W-1:0] prod_p1;
  logic signed [ACC_W-1:0]  prod_ext_p1, sum_p1;
  logic                     add_ovf_p1;

  acc_state_t               acc_state, acc_state_nxt;
  logic signed [ACC_W-1:0]  acc_p2, acc_nxt;
  logic [CNT_W-1:0]         cnt_p2, cnt_nxt;
  logic                     ovf_p2, ovf_nxt;

  out_state_t               out_state, out_state_nxt;
  logic signed [ACC_W-1:0]  out_acc_nxt;
  logic [CNT_W-1:0]         out_len_nxt;
  logic                     out_ovf_nxt;

  logic term_end, s1_adv, xfer, load_out;

  // A vector ends on an explicit last term or when the counter reaches MAX_LEN.
  assign term_end  = last_p1 || (cnt_p2 == CNT_W'(MAX_LEN-1));
  // Only a terminating term facing a full, unaccepted output stalls.
  assign s1_adv    = vld_p1 && !(term_end && out_valid && !out_ready);
  assign in_ready  = !vld_p1 || s1_adv;
  assign xfer      = in_valid && in_ready;
  assign load_out  = s1_adv && term_end;
  assign out_valid = (out_state == OUT_FULL);

  // ---- Stage p1: operand register ----
  // Capture operands on transfer; drop valid when the term moves on with no replacement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      a_p1    <= '0;
      b_p1    <= '0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      last_p1 <= in_last;
      a_p1    <= in_a;
      b_p1    <= in_b;
    end else if (s1_adv) begin
      vld_p1  <= 1'b0;
    end
  end

  signed_arrayMul u_mul (
    .a (a_p1),
    .b (b_p1),
    .p (prod_p1)
  );

  assign prod_ext_p1 = ACC_W'(prod_p1);
  assign sum_p1      = acc_p2 + prod_ext_p1;
  assign add_ovf_p1  = sadd_ovf(acc_p2[ACC_W-1], prod_ext_p1[ACC_W-1], sum_p1[ACC_W-1]);

  // ---- Stage p2: accumulator ----
  // Accumulator next state: keep summing, or clear once the vector is handed off.
  always_comb begin
    acc_state_nxt = acc_state;
    acc_nxt       = acc_p2;
    cnt_nxt       = cnt_p2;
    ovf_nxt       = ovf_p2;
    if (s1_adv) begin
      if (term_end) begin
        acc_state_nxt = ACC_IDLE;
        acc_nxt       = '0;
        cnt_nxt       = '0;
        ovf_nxt       = 1'b0;
      end else begin
        acc_state_nxt = ACC_RUN;
        acc_nxt       = sum_p1;
        cnt_nxt       = cnt_p2 + CNT_W'(1);
        ovf_nxt       = ovf_p2 | add_ovf_p1;
      end
    end
  end

  // Accumulator state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_state <= ACC_IDLE;
      acc_p2    <= '0;
      cnt_p2    <= '0;
      ovf_p2    <= 1'b0;
    end else begin
      acc_state <= acc_state_nxt;
      acc_p2    <= acc_nxt;
      cnt_p2    <= cnt_nxt;
      ovf_p2    <= ovf_nxt;
    end
  end

  // Output register next state: a new result may load in the same cycle the old one is taken.
  always_comb begin
    out_state_nxt = out_state;
    out_acc_nxt   = out_acc;
    out_len_nxt   = out_len;
    out_ovf_nxt   = out_ovf;
    if (load_out) begin
      out_state_nxt = OUT_FULL;
      out_acc_nxt   = sum_p1;
      out_len_nxt   = cnt_p2 + CNT_W'(1);
      out_ovf_nxt   = ovf_p2 | add_ovf_p1;
    end else if (out_valid && out_ready) begin
      out_state_nxt = OUT_EMPTY;
    end
  end

  // Output state register; fields only change on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state <= OUT_EMPTY;
      out_acc   <= '0;
      out_len   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_state <= out_state_nxt;
      out_acc   <= out_acc_nxt;
      out_len   <= out_len_nxt;
      out_ovf   <= out_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_signed_mac4_stream.sv
// Directed bench for signed_mac4_stream: default, 8-bit accumulator and MAX_LEN=4 instances.
module tb_signed_mac4_stream;

  logic       clk, rst_n;
  logic       in_valid, in_last, out_ready;
  logic [3:0] in_a, in_b;

  logic              rdy_d, ov_d, of_d;
  logic signed [11:0] acc_d;
  logic [4:0]        len_d;

  logic              rdy_o, ov_o, of_o;
  logic signed [7:0] acc_o;
  logic [4:0]        len_o;

  logic              rdy_l, ov_l, of_l;
  logic signed [11:0] acc_l;
  logic [2:0]        len_l;

  int n_tests = 0;
  int n_fail  = 0;

  signed_mac4_stream u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_d),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov_d),
    .out_ready(out_ready), .out_acc(acc_d), .out_len(len_d), .out_ovf(of_d)
  );

  signed_mac4_stream #(.ACC_W(8)) u_ovf (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov_o),
    .out_ready(out_ready), .out_acc(acc_o), .out_len(len_o), .out_ovf(of_o)
  );

  signed_mac4_stream #(.MAX_LEN(4)) u_len (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_l),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov_l),
    .out_ready(out_ready), .out_acc(acc_l), .out_len(len_l), .out_ovf(of_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input bit v, input int a, input int b, input bit l);
    in_valid = v;
    in_a     = 4'(a);
    in_b     = 4'(b);
    in_last  = l;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++; if (rdy_d !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0d want 1", rdy_d); end
    n_tests++; if (ov_d !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0d want 0", ov_d); end
    n_tests++; if (acc_d !== 0) begin n_fail++; $display("FAIL reset_out_acc: got %0d want 0", acc_d); end
    n_tests++; if (len_d !== 0 || of_d !== 1'b0) begin n_fail++; $display("FAIL reset_len_ovf: got %0d/%0d want 0/0", len_d, of_d); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_reset();
    drive(1, 3, 2, 0);   @(negedge clk);
    drive(1, -4, 5, 0);  @(negedge clk);
    drive(1, -8, -8, 1);
    n_tests++; if (rdy_d !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %0d want 1", rdy_d); end
    @(negedge clk);
    drive(0, 0, 0, 0);
    n_tests++; if (ov_d !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %0d want 0", ov_d); end
    @(negedge clk);
    n_tests++; if (ov_d !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0d want 1", ov_d); end
    n_tests++; if (acc_d !== 50) begin n_fail++; $display("FAIL basic_acc: got %0d want 50", acc_d); end
    n_tests++; if (len_d !== 3 || of_d !== 1'b0) begin n_fail++; $display("FAIL basic_len_ovf: got %0d/%0d want 3/0", len_d, of_d); end
    @(negedge clk);
    n_tests++; if (ov_d !== 1'b0) begin n_fail++; $display("FAIL basic_accept: got %0d want 0", ov_d); end
  endtask

  task automatic test_overflow();
    do_reset();
    drive(1, -8, -8, 0); @(negedge clk);
    drive(1, -8, -8, 1); @(negedge clk);
    drive(1, 1, 1, 1);   @(negedge clk);
    drive(0, 0, 0, 0);
    n_tests++; if (ov_o !== 1'b1 || acc_o !== -128) begin n_fail++; $display("FAIL ovf_acc: got %0d (valid %0d) want -128", acc_o, ov_o); end
    n_tests++; if (of_o !== 1'b1 || len_o !== 2) begin n_fail++; $display("FAIL ovf_flag: got ovf %0d len %0d want 1/2", of_o, len_o); end
    n_tests++; if (of_d !== 1'b0 || acc_d !== 128) begin n_fail++; $display("FAIL ovf_wide_acc: got %0d ovf %0d want 128/0", acc_d, of_d); end
    @(negedge clk);
    n_tests++; if (ov_o !== 1'b1 || acc_o !== 1 || of_o !== 1'b0 || len_o !== 1) begin n_fail++; $display("FAIL ovf_next_vec: got %0d ovf %0d len %0d want 1/0/1", acc_o, of_o, len_o); end
  endtask

  task automatic test_implicit_term();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      drive(1, 1, 1, i == 6);
      @(negedge clk);
      if (i == 5) begin
        n_tests++; if (ov_l !== 1'b1 || acc_l !== 4 || len_l !== 4) begin n_fail++; $display("FAIL implicit_first: got %0d len %0d valid %0d want 4/4/1", acc_l, len_l, ov_l); end
      end
      if (i == 6) begin
        n_tests++; if (ov_l !== 1'b0) begin n_fail++; $display("FAIL implicit_gap: got %0d want 0", ov_l); end
      end
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (ov_l !== 1'b1 || acc_l !== 2 || len_l !== 2) begin n_fail++; $display("FAIL implicit_second: got %0d len %0d valid %0d want 2/2/1", acc_l, len_l, ov_l); end
    n_tests++; if (ov_d !== 1'b1 || acc_d !== 6 || len_d !== 6) begin n_fail++; $display("FAIL implicit_default_len: got %0d len %0d want 6/6", acc_d, len_d); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    drive(1, 7, 7, 1);  @(negedge clk);
    drive(1, -1, 1, 1); @(negedge clk);
    drive(1, 2, 2, 1);
    n_tests++; if (ov_d !== 1'b1 || acc_d !== 49) begin n_fail++; $display("FAIL bp_first: got %0d valid %0d want 49/1", acc_d, ov_d); end
    n_tests++; if (rdy_d !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %0d want 0", rdy_d); end
    repeat (2) begin
      @(negedge clk);
      n_tests++; if (ov_d !== 1'b1 || acc_d !== 49 || len_d !== 1 || rdy_d !== 1'b0) begin n_fail++; $display("FAIL bp_hold: got %0d valid %0d ready %0d want 49/1/0", acc_d, ov_d, rdy_d); end
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (rdy_d !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0d want 1", rdy_d); end
    @(negedge clk);
    drive(0, 0, 0, 0);
    n_tests++; if (ov_d !== 1'b1 || acc_d !== -1) begin n_fail++; $display("FAIL bp_second: got %0d valid %0d want -1/1", acc_d, ov_d); end
    @(negedge clk);
    n_tests++; if (ov_d !== 1'b1 || acc_d !== 4) begin n_fail++; $display("FAIL bp_third: got %0d valid %0d want 4/1", acc_d, ov_d); end
    @(negedge clk);
    n_tests++; if (ov_d !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %0d want 0", ov_d); end
  endtask

  task automatic test_back_to_back();
    int av [5] = '{1, 2, -8, 7, -8};
    int bv [5] = '{1, -3, 7, -8, -8};
    int ev [5] = '{1, -6, -56, -56, 64};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, av[i], bv[i], 1);
      @(negedge clk);
      if (i > 0) begin
        n_tests++; if (ov_d !== 1'b1 || acc_d !== ev[i-1]) begin n_fail++; $display("FAIL b2b_%0d: got %0d valid %0d want %0d/1", i-1, acc_d, ov_d, ev[i-1]); end
      end
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (ov_d !== 1'b1 || acc_d !== ev[4]) begin n_fail++; $display("FAIL b2b_4: got %0d valid %0d want %0d/1", acc_d, ov_d, ev[4]); end
    @(negedge clk);
    n_tests++; if (ov_d !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %0d want 0", ov_d); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    drive(1, 3, 3, 1); @(negedge clk);
    drive(1, 5, 5, 0); @(negedge clk);
    drive(1, 6, 6, 0); @(negedge clk);
    drive(0, 0, 0, 0);
    n_tests++; if (ov_d !== 1'b1 || acc_d !== 9) begin n_fail++; $display("FAIL mid_pending: got %0d valid %0d want 9/1", acc_d, ov_d); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (ov_d !== 1'b0 || acc_d !== 0 || len_d !== 0 || of_d !== 1'b0) begin n_fail++; $display("FAIL mid_async_clear: got %0d valid %0d len %0d want 0/0/0", acc_d, ov_d, len_d); end
    n_tests++; if (rdy_d !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %0d want 1", rdy_d); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (ov_d !== 1'b0) begin n_fail++; $display("FAIL mid_no_output: got %0d want 0", ov_d); end
    drive(1, 2, 3, 1); @(negedge clk);
    drive(0, 0, 0, 0); @(negedge clk);
    n_tests++; if (ov_d !== 1'b1 || acc_d !== 6 || len_d !== 1) begin n_fail++; $display("FAIL mid_after: got %0d len %0d valid %0d want 6/1/1", acc_d, len_d, ov_d); end
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_overflow();
    test_implicit_term();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
